// File: rtl/stream_max_finder.sv
// Streams a window of N samples through an external comparator and keeps the running max and its index.
// Optional STREAM_ABORT_EN adds an abort input that drops the window back to IDLE without done_tick.
module stream_max_finder #(
    parameter int W  = 8,
    parameter int N  = 16,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [W-1:0]  din,
    input  logic          din_valid,
`ifdef STREAM_ABORT_EN
    input  logic          abort,
`endif
    output logic          din_ready,
    output logic [W-1:0]  comp_a,
    output logic [W-1:0]  comp_b,
    output logic          comp_mode,
    input  logic          comp_agtb,
    output logic [W-1:0]  max_val,
    output logic [CW-1:0] max_idx,
    output logic          busy,
    output logic          done_tick
);

    typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W-1:0]    max_val_q, max_val_d;
    logic [CW-1:0]   max_idx_q, max_idx_d;
    logic            mode_q, mode_d;

    assign comp_a    = din;
    assign comp_b    = max_val_q;
    assign comp_mode = mode_q;
    assign max_val   = max_val_q;
    assign max_idx   = max_idx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        mode_d    = mode_q;
        din_ready = 1'b0;
        busy      = 1'b0;
        done_tick = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    count_d = '0;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                busy      = 1'b1;
                din_ready = 1'b1;
`ifdef STREAM_ABORT_EN
                if (abort) begin
                    state_d = IDLE;
                end else
`endif
                if (din_valid) begin
                    // first sample seeds the max; later ones need a strict win so ties keep the earliest index
                    if (count_q == '0 || comp_agtb) begin
                        max_val_d = din;
                        max_idx_d = count_q;
                    end
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(N - 1))
                        state_d = DONE;
                end
            end
            DONE: begin
                done_tick = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_stream_max_finder.sv
// Directed bench for stream_max_finder (N=4, W=8) with a behavioural comparator on the comp_* bus.
module tb_stream_max_finder;
    localparam int W = 8, N = 4, CW = 2;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0;
    logic [W-1:0]  din = '0;
    logic          din_valid = 1'b0, abort = 1'b0;
    logic          din_ready, comp_mode, comp_agtb, busy, done_tick;
    logic [W-1:0]  comp_a, comp_b, max_val;
    logic [CW-1:0] max_idx;

    int vecs = 0, fails = 0, dt_total = 0, dt_base;

    stream_max_finder #(.W(W), .N(N), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .din(din), .din_valid(din_valid),
`ifdef STREAM_ABORT_EN
        .abort(abort),
`endif
        .din_ready(din_ready), .comp_a(comp_a), .comp_b(comp_b),
        .comp_mode(comp_mode), .comp_agtb(comp_agtb),
        .max_val(max_val), .max_idx(max_idx), .busy(busy), .done_tick(done_tick)
    );

    // reference dual comparator
    assign comp_agtb = comp_mode ? ($signed(comp_a) > $signed(comp_b)) : (comp_a > comp_b);

    always #5 clk = ~clk;
    always @(posedge clk) if (done_tick === 1'b1) dt_total++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // One window; gap = idle cycles between samples, meddle = pulse start and flip mode mid-window.
    task automatic run_window(input string tag, input logic m,
                              input logic [7:0] s0, s1, s2, s3, input int gap, input bit meddle);
        logic [7:0] s [4];
        s = '{s0, s1, s2, s3};
        dt_base = dt_total;
        start = 1'b1; mode = m; step(); start = 1'b0;
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".cmode"}, comp_mode, m);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    din_valid = 1'b0; din = 8'hFF; #1;
                    chk({tag, ".gap_ready"}, din_ready, 1);
                    step();
                end
            end
            if (meddle && i == 2) begin start = 1'b1; mode = ~m; end
            din_valid = 1'b1; din = s[i]; #1;
            chk({tag, ".ready"}, din_ready, 1);
            step();
            start = 1'b0;
        end
        din_valid = 1'b0;
        chk({tag, ".done"}, done_tick, 1);
        chk({tag, ".done_rdy"}, din_ready, 0);
        step();
        chk({tag, ".done_once"}, dt_total - dt_base, 1);
        chk({tag, ".idle_busy"}, busy, 0);
    endtask

    initial begin
        #1;
        chk("rst.max_val", max_val, 0);
        chk("rst.max_idx", max_idx, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ready", din_ready, 0);
        chk("rst.done", done_tick, 0);
        chk("rst.cmode", comp_mode, 0);
        step(); reset = 1'b0; step();

        // 1: unsigned
        run_window("t1", 1'b0, 8'h0F, 8'hF0, 8'h03, 8'h07, 0, 1'b0);
        chk("t1.max_val", max_val, 8'hF0);
        chk("t1.max_idx", max_idx, 1);
        chk("t1.comp_b", comp_b, 8'hF0);
        step();
        chk("t1.hold_val", max_val, 8'hF0);

        // 2: signed, 0x0F (15) beats 0xF0 (-16)
        run_window("t2", 1'b1, 8'h0F, 8'hF0, 8'h03, 8'h07, 0, 1'b0);
        chk("t2.max_val", max_val, 8'h0F);
        chk("t2.max_idx", max_idx, 0);

        // 3: stalls with 0xFF parked on din, plus a tie
        run_window("t3", 1'b0, 8'd5, 8'd9, 8'd9, 8'd2, 3, 1'b0);
        chk("t3.max_val", max_val, 8'd9);
        chk("t3.max_idx", max_idx, 1);

        // 4: start and mode flip during TRACK are ignored
        run_window("t4", 1'b0, 8'h0F, 8'hF0, 8'h03, 8'h07, 0, 1'b1);
        chk("t4.max_val", max_val, 8'hF0);
        chk("t4.max_idx", max_idx, 1);
        chk("t4.cmode", comp_mode, 0);

        // 5: async reset after second accept
        dt_base = dt_total;
        start = 1'b1; mode = 1'b0; step(); start = 1'b0;
        din_valid = 1'b1; din = 8'h0F; step();
        din = 8'hF0; step();
        din_valid = 1'b0;
        chk("t5.partial_val", max_val, 8'hF0);
        #2 reset = 1'b1; #1;
        chk("t5.rst_val", max_val, 0);
        chk("t5.rst_idx", max_idx, 0);
        chk("t5.rst_busy", busy, 0);
        chk("t5.rst_ready", din_ready, 0);
        step(); step(); reset = 1'b0; step(); step();
        chk("t5.no_done", dt_total - dt_base, 0);
        run_window("t5b", 1'b0, 8'h11, 8'h22, 8'h80, 8'h7F, 0, 1'b0);
        chk("t5b.max_val", max_val, 8'h80);
        chk("t5b.max_idx", max_idx, 2);

`ifdef STREAM_ABORT_EN
        // 6: abort wins over a same-cycle accept
        dt_base = dt_total;
        start = 1'b1; mode = 1'b0; step(); start = 1'b0;
        din_valid = 1'b1; din = 8'h10; step();
        din = 8'h20; step();
        din = 8'h30; abort = 1'b1; step();
        abort = 1'b0; din_valid = 1'b0;
        chk("t6.busy", busy, 0);
        chk("t6.max_val", max_val, 8'h20);
        chk("t6.max_idx", max_idx, 1);
        step(); step();
        chk("t6.no_done", dt_total - dt_base, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
